// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed display: steps the 4:1 data-mux select,
// blanks every digit while the select settles, then latches the byte and lights one digit.
module mux_scan_ctrl #(
   parameter int DIV   = 100000,
   parameter int BLANK = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             hold,
   input  logic [WIDTH-1:0] mux_y,
   output logic [1:0]       sel,
   output logic [3:0]       an,
   output logic [WIDTH-1:0] seg_data,
   output logic             scan_done
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BLK_W = (BLANK > 1) ? $clog2(BLANK) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK - 1);
   localparam logic [3:0] AN_OFF = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_LOAD  = 2'd2,
      ST_SHOW  = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [1:0]         sel_r, sel_s;
   logic [3:0]         an_r, an_s;
   logic [WIDTH-1:0]   seg_r, seg_s;
   logic               done_r, done_s;
   logic [BLK_W-1:0]   blk_cnt_r, blk_cnt_s;
   logic [DIV_W-1:0]   pre_cnt_r, pre_cnt_s;

   // Active-low one-hot digit enable for a given select value.
   function automatic logic [3:0] digit_dec(input logic [1:0] s);
      return ~(4'b0001 << s);
   endfunction

   // Next-state and next-output logic; en low overrides everything.
   always_comb begin
      state_s   = state_r;
      sel_s     = sel_r;
      an_s      = an_r;
      seg_s     = seg_r;
      done_s    = 1'b0;
      blk_cnt_s = blk_cnt_r;
      pre_cnt_s = pre_cnt_r;

      if (!en) begin
         state_s   = ST_IDLE;
         an_s      = AN_OFF;
         blk_cnt_s = '0;
         pre_cnt_s = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               an_s      = AN_OFF;
               blk_cnt_s = '0;
               pre_cnt_s = '0;
               state_s   = ST_BLANK;
            end
            ST_BLANK: begin
               an_s = AN_OFF;
               if (blk_cnt_r == BLK_LAST) begin
                  blk_cnt_s = '0;
                  state_s   = ST_LOAD;
               end else begin
                  blk_cnt_s = blk_cnt_r + 1'b1;
               end
            end
            ST_LOAD: begin
               seg_s     = mux_y;
               an_s      = digit_dec(sel_r);
               pre_cnt_s = '0;
               state_s   = ST_SHOW;
            end
            ST_SHOW: begin
               if (pre_cnt_r == DIV_LAST) begin
                  pre_cnt_s = '0;
                  // Holding re-samples the same digit so live data still reaches the display.
                  if (hold) begin
                     seg_s = mux_y;
                  end else begin
                     sel_s   = sel_r + 2'd1;
                     an_s    = AN_OFF;
                     done_s  = (sel_r == 2'd3);
                     state_s = ST_BLANK;
                  end
               end else begin
                  pre_cnt_s = pre_cnt_r + 1'b1;
               end
            end
            default: begin
               state_s   = ST_IDLE;
               an_s      = AN_OFF;
               blk_cnt_s = '0;
               pre_cnt_s = '0;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         sel_r     <= 2'd0;
         an_r      <= AN_OFF;
         seg_r     <= '0;
         done_r    <= 1'b0;
         blk_cnt_r <= '0;
         pre_cnt_r <= '0;
      end else begin
         state_r   <= state_s;
         sel_r     <= sel_s;
         an_r      <= an_s;
         seg_r     <= seg_s;
         done_r    <= done_s;
         blk_cnt_r <= blk_cnt_s;
         pre_cnt_r <= pre_cnt_s;
      end
   end

   assign sel       = sel_r;
   assign an        = an_r;
   assign seg_data  = seg_r;
   assign scan_done = done_r;

endmodule
